// File: rtl/gpio_in_conditioner.sv
// rtl/gpio_in_conditioner.sv - per-bit synchronizer, debouncer, edge pulses and sticky change flags for switch inputs
module gpio_in_conditioner #(
    parameter int WIDTH    = 8,
    parameter int DB_COUNT = 250000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] event_flags
);

    // Counter width is derived from DB_COUNT and is not meant to be overridden.
    localparam int CNT_W = (DB_COUNT > 1) ? $clog2(DB_COUNT + 1) : 1;

    // Terminal count: the cycle on which a pending level change is accepted.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Two-stage synchronizer; only sync2 is trusted downstream.
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Per-bit stability counters, one per input bit.
    logic [CNT_W-1:0] cnt [WIDTH];

    // High for a bit when its synchronized level disagrees with the accepted level.
    logic [WIDTH-1:0] differ;

    // High for a bit on the cycle its pending change has been stable long enough.
    logic [WIDTH-1:0] accept;

    // Change pulses feeding the sticky flags, taken from the registered pulses
    // so a clear strobe issued during a pulse cycle loses to the set.
    logic [WIDTH-1:0] pulse_any;

    // Flag next-state: set on a pulse, otherwise cleared by the strobe, otherwise held.
    logic [WIDTH-1:0] flags_next;

    // Synchronize the raw asynchronous switch levels into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_in;
            sync2 <= sync1;
        end
    end

    // Decide per bit whether the disagreement has lasted the full debounce window.
    always_comb begin
        differ = '0;
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            differ[i] = (sync2[i] != gpio_in[i]);
            accept[i] = differ[i] && (cnt[i] == CNT_MAX);
        end
    end

    // Per-bit counters: any cycle of agreement restarts the window, and the
    // counter returns to zero on acceptance so it never passes CNT_MAX.
    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cnt
            // Count consecutive cycles of disagreement for this bit.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt[g] <= '0;
                end else if (!differ[g]) begin
                    cnt[g] <= '0;
                end else if (accept[g]) begin
                    cnt[g] <= '0;
                end else begin
                    cnt[g] <= cnt[g] + CNT_ONE;
                end
            end
        end
    endgenerate

    // Accepted level: take the synchronized value only for bits that matured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_in <= '0;
        end else begin
            gpio_in <= (gpio_in & ~accept) | (sync2 & accept);
        end
    end

    // Edge pulses are registered alongside gpio_in so they line up with the
    // first cycle of the new level and last exactly one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            rise_pulse <= accept & sync2;
            fall_pulse <= accept & ~sync2;
        end
    end

    // Sticky flag next-state: a pulse sets, a clear strobe clears, set wins.
    always_comb begin
        pulse_any  = rise_pulse | fall_pulse;
        flags_next = pulse_any | (event_flags & ~clr);
    end

    // Latch change events until software clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            event_flags <= '0;
        end else begin
            event_flags <= flags_next;
        end
    end

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb/tb_gpio_in_conditioner.sv - scoreboard bench for gpio_in_conditioner with WIDTH=8, DB_COUNT=4
module tb_gpio_in_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw_in;
    logic [7:0] clr;
    logic [7:0] gpio_in;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
    logic [7:0] event_flags;

    gpio_in_conditioner #(
        .WIDTH   (8),
        .DB_COUNT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sw_in      (sw_in),
        .clr        (clr),
        .gpio_in    (gpio_in),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .event_flags(event_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] f;
        logic [7:0] e;
    } ev_t;

    ev_t         exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] prev     = '0;

    task automatic expect_ev(input int at, input logic [7:0] g, input logic [7:0] r,
                             input logic [7:0] f, input logic [7:0] e);
        ev_t ev;
        ev.at = at;
        ev.g  = g;
        ev.r  = r;
        ev.f  = f;
        ev.e  = e;
        exp_q.push_back(ev);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [31:0] req);
        logic [31:0] got;
        got = {gpio_in, rise_pulse, fall_pulse, event_flags};
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: gpio/rise/fall/flags got=%h required=%h (cyc %0d)", name, got, req, cyc);
        end
    endtask

    // Monitor: every change of the output tuple is an event popped from the scoreboard.
    initial begin
        logic [31:0] cur;
        logic [31:0] req;
        ev_t         ev;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cur = {gpio_in, rise_pulse, fall_pulse, event_flags};
                if (cur !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event: cyc=%0d got=%h required=no change", cyc, cur);
                    end else begin
                        ev  = exp_q.pop_front();
                        req = {ev.g, ev.r, ev.f, ev.e};
                        if (ev.at != cyc || cur !== req) begin
                            failures++;
                            $display("FAIL event: got cyc=%0d tuple=%h required cyc=%0d tuple=%h",
                                     cyc, cur, ev.at, req);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        int  n;
        ev_t ev;

        reset = 1'b0;
        sw_in = 8'h00;
        clr   = 8'h00;
        tick(3);
        check_now("reset_hold", 32'h0);
        reset  = 1'b1;
        prev   = '0;
        mon_en = 1'b1;
        tick(20);
        check_now("idle_20", 32'h0);

        // Clean step 0x00 -> 0x05.
        n = cyc;
        sw_in = 8'h05;
        expect_ev(n + 6, 8'h05, 8'h05, 8'h00, 8'h00);
        expect_ev(n + 7, 8'h05, 8'h00, 8'h00, 8'h05);
        tick(5);
        check_now("step_not_before", 32'h0);
        tick(5);
        check_now("step_after", {8'h05, 8'h00, 8'h00, 8'h05});

        // Three-cycle glitch on bit 3 must be filtered.
        sw_in = 8'h0D;
        tick(3);
        sw_in = 8'h05;
        tick(10);
        check_now("glitch_filtered", {8'h05, 8'h00, 8'h00, 8'h05});

        // Six-cycle pulse on bit 3 passes, then release is debounced.
        n = cyc;
        sw_in = 8'h0D;
        expect_ev(n + 6,  8'h0D, 8'h08, 8'h00, 8'h05);
        expect_ev(n + 7,  8'h0D, 8'h00, 8'h00, 8'h0D);
        expect_ev(n + 12, 8'h05, 8'h00, 8'h08, 8'h0D);
        expect_ev(n + 13, 8'h05, 8'h00, 8'h00, 8'h0D);
        tick(6);
        sw_in = 8'h05;
        tick(10);
        check_now("pulse6_done", {8'h05, 8'h00, 8'h00, 8'h0D});

        // Write-1-to-clear, one bit at a time.
        n = cyc;
        clr = 8'h08;
        expect_ev(n + 1, 8'h05, 8'h00, 8'h00, 8'h05);
        tick(1);
        clr = 8'h00;
        tick(3);
        n = cyc;
        clr = 8'h01;
        expect_ev(n + 1, 8'h05, 8'h00, 8'h00, 8'h04);
        tick(1);
        clr = 8'h00;
        tick(2);
        check_now("clr_bit0", {8'h05, 8'h00, 8'h00, 8'h04});
        n = cyc;
        clr = 8'h04;
        expect_ev(n + 1, 8'h05, 8'h00, 8'h00, 8'h00);
        tick(1);
        clr = 8'h00;
        tick(2);

        // Clear coinciding with fall_pulse[2]: set wins, then held clear empties it.
        n = cyc;
        sw_in = 8'h01;
        expect_ev(n + 6, 8'h01, 8'h00, 8'h04, 8'h00);
        expect_ev(n + 7, 8'h01, 8'h00, 8'h00, 8'h04);
        expect_ev(n + 8, 8'h01, 8'h00, 8'h00, 8'h00);
        tick(6);
        clr = 8'h04;
        tick(1);
        check_now("set_wins", {8'h01, 8'h00, 8'h00, 8'h04});
        tick(3);
        check_now("clr_held", {8'h01, 8'h00, 8'h00, 8'h00});
        clr = 8'h00;
        tick(3);

        // Switches high through reset: startup rise event.
        mon_en = 1'b0;
        sw_in  = 8'hFF;
        reset  = 1'b0;
        #1;
        check_now("async_reset", 32'h0);
        tick(3);
        reset = 1'b1;
        n = cyc;
        prev   = '0;
        mon_en = 1'b1;
        expect_ev(n + 6, 8'hFF, 8'hFF, 8'h00, 8'h00);
        expect_ev(n + 7, 8'hFF, 8'h00, 8'h00, 8'hFF);
        tick(5);
        check_now("por_not_before", 32'h0);
        tick(5);
        check_now("por_after", {8'hFF, 8'h00, 8'h00, 8'hFF});

        // Reset while bit 1 is mid-count: no fall pulse, full latency afterwards.
        sw_in = 8'hFD;
        tick(4);
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check_now("midcount_reset", 32'h0);
        tick(2);
        reset = 1'b1;
        n = cyc;
        prev   = '0;
        mon_en = 1'b1;
        expect_ev(n + 6, 8'hFD, 8'hFD, 8'h00, 8'h00);
        expect_ev(n + 7, 8'hFD, 8'h00, 8'h00, 8'hFD);
        tick(5);
        check_now("midcount_not_before", 32'h0);
        tick(5);
        check_now("midcount_after", {8'hFD, 8'h00, 8'h00, 8'hFD});

        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event: got none required cyc=%0d tuple=%h", ev.at, {ev.g, ev.r, ev.f, ev.e});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Conditions raw slide-switch inputs before they reach the multi-cycle core's GPIO_In port.
- Per bit: 2-flop synchronizer, counter-based debouncer, rise/fall edge pulses and a sticky event register with write-1-to-clear.
- Runs in the fast PLL clock domain (clk_gen), upstream of the core.
- Gives the core glitch-free, metastability-safe levels plus latched change events that software can poll at the slow core clock.

Parameters:
- WIDTH, 8: number of GPIO input bits conditioned.
- DB_COUNT, 250000: consecutive stable cycles required before a level change is accepted; 5 ms at 50 MHz. Legal range >= 1.
- CNT_W, $clog2(DB_COUNT+1): per-bit counter width. Derived; not overridden.

Ports:
- clk  input  1  system clock (PLL output); all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sw_in  input  WIDTH  raw asynchronous switch levels.
- clr  input  WIDTH  write-1-to-clear strobes for event_flags, one per bit, sampled each clk.
- gpio_in  output  WIDTH  debounced level; feeds the core's GPIO_In.
- rise_pulse  output  WIDTH  one-cycle pulse when gpio_in[i] goes 0->1.
- fall_pulse  output  WIDTH  one-cycle pulse when gpio_in[i] goes 1->0.
- event_flags  output  WIDTH  sticky "bit i changed" flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - sync1, sync2, per-bit counters, gpio_in, rise_pulse, fall_pulse and event_flags all go to 0 immediately.
  - Release is synchronous to clk, handled by the integrator.
- Synchronizer: sync1 <= sw_in and sync2 <= sync1 each edge. Only sync2 is used downstream.
- Debounce, per bit i, independent of other bits:
  - If sync2[i] == gpio_in[i]: cnt[i] <= 0.
  - Else if cnt[i] == DB_COUNT-1: gpio_in[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any single cycle of agreement restarts the count, so glitches shorter than DB_COUNT cycles never reach gpio_in.
- Latency: a clean step on sw_in first captured into sync1 at edge E appears on gpio_in after edge E+DB_COUNT+1. That is DB_COUNT+2 edges total, counting edge E.
- Edge pulses:
  - rise_pulse[i] and fall_pulse[i] are registered and asserted for exactly the one cycle in which gpio_in[i] holds its new value.
  - Never both high for the same bit.
  - Low in all other cycles.
- event_flags[i]:
  - Set on any rise or fall pulse of bit i.
  - Cleared when clr[i]=1 and no pulse on bit i that cycle.
  - If pulse and clr coincide, set wins (flag = 1).
  - clr[i] held high continuously keeps the flag at 0 except in pulse cycles.
- DB_COUNT=1: gpio_in follows sync2 with one extra cycle of delay; no filtering beyond that.
- Counter never exceeds DB_COUNT-1; no wrap.
- Switch held high through reset release: after DB_COUNT+2 edges gpio_in goes 1 and a rise_pulse plus event flag is produced. This is intentional and reported to software as a startup event.
- Reset asserted mid-count: count is discarded; gpio_in returns to 0 without generating a fall_pulse.
- No combinational path from sw_in or clr to any output.

Test Plan (WIDTH=8, DB_COUNT=4):
- Reset, sw_in=0x00 steady for 20 cycles -> gpio_in=0x00, no pulses, event_flags=0x00.
- sw_in step 0x00->0x05 at edge E -> gpio_in=0x05 after edge E+5, not before; rise_pulse=0x05 for exactly one cycle; event_flags=0x05 thereafter.
- sw_in[3] glitches high for 3 cycles then low -> gpio_in[3] stays 0, no pulses. A 6-cycle high pulse -> gpio_in[3] rises, then falls after the release is stable; rise and fall pulses are one cycle each.
- event_flags=0x05, pulse clr=0x01 for one cycle -> event_flags=0x04. Assert clr[2] in the same cycle as a fall_pulse[2] -> flag stays 1.
- sw_in=0xFF held during reset, release reset -> gpio_in=0xFF after 6 edges, rise_pulse=0xFF for one cycle.
- Reset asserted while bit 1 is mid-count at cnt=2 -> all outputs 0 asynchronously. After release with sw_in unchanged, the full DB_COUNT+2-edge latency applies again.
